// File: rtl/icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl
//
// Control FSM for a direct-mapped, one-word-per-line instruction cache.
// A fetch is looked up against externally stored valid/tag/data memories.
// These memories have a registered read: the index driven on CacheIndexRead
// is returned on Valid/TagRead/DataRead one cycle later. On a miss the word
// is fetched from the next level and written into the line. The same word
// is delivered to the requester in that cycle.
//
// Address split (byte address): tag = addr[31:9], index = addr[8:2],
// addr[1:0] ignored.
//
// Optional feature: define ICACHE_PERF_EN to add the MissCount output, a
// 16-bit saturating count of lookup misses.
//
// Ports
//   clk             in   sole clock, rising edge
//   nReset          in   asynchronous active-low reset
//   FetchReq        in   fetch request (held by requester until Hit)
//   FetchAddr       in   fetch byte address
//   Valid           in   stored valid bit (registered read)
//   TagRead         in   stored tag (registered read)
//   DataRead        in   stored instruction (registered read)
//   CacheIndexRead  out  read index to the valid/tag/data memories
//   CacheIndexWrite out  index of the line being refilled
//   WriteValid      out  write strobe: set valid, write tag and data
//   TagWrite        out  tag to write
//   DataWrite       out  instruction to write
//   MemReq          out  refill request to next level
//   MemAddr         out  refill word address
//   MemAck          in   refill data valid
//   MemData         in   refill data
//   MissCount       out  saturating miss counter (ICACHE_PERF_EN only)
//   Hit             out  instruction delivered this cycle
//   InstOut         out  delivered instruction
//   Stall           out  fetch stall
// ---------------------------------------------------------------------------
module icache_refill_ctrl #(
  parameter int INDEX_W = 7,
  parameter int TAG_W   = 23
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               FetchReq,
  input  logic [31:0]        FetchAddr,
  input  logic               Valid,
  input  logic [TAG_W-1:0]   TagRead,
  input  logic [31:0]        DataRead,
  output logic [INDEX_W-1:0] CacheIndexRead,
  output logic [INDEX_W-1:0] CacheIndexWrite,
  output logic               WriteValid,
  output logic [TAG_W-1:0]   TagWrite,
  output logic [31:0]        DataWrite,
  output logic               MemReq,
  output logic [31:0]        MemAddr,
  input  logic               MemAck,
  input  logic [31:0]        MemData,
`ifdef ICACHE_PERF_EN
  output logic [15:0]        MissCount,
`endif
  output logic               Hit,
  output logic [31:0]        InstOut,
  output logic               Stall
);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    UPDATE
  } state_t;

  state_t       state_q, state_d;

  // Only the word address is kept; the byte offset never matters.
  logic [29:0]  addr_q, addr_d;
  logic [31:0]  data_q, data_d;

  logic [INDEX_W-1:0] addr_index;
  logic [TAG_W-1:0]   addr_tag;
  logic               lookup_hit;
  logic               unused_byte_offset;

  assign addr_index         = addr_q[INDEX_W-1:0];
  assign addr_tag           = addr_q[29 -: TAG_W];
  assign unused_byte_offset = ^FetchAddr[1:0];

  // The memory outputs seen in LOOKUP belong to the index that was presented
  // in the accepting cycle, i.e. to the address now held in addr_q.
  assign lookup_hit = Valid && (TagRead == addr_tag);

  // State, latched address and captured refill word.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next-state and output logic. Data-type outputs are driven to zero when
  // not meaningful so that reset and idle show a clean all-zero interface.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    data_d          = data_q;
    CacheIndexRead  = FetchAddr[INDEX_W+1:2];
    CacheIndexWrite = '0;
    WriteValid      = 1'b0;
    TagWrite        = '0;
    DataWrite       = '0;
    MemReq          = 1'b0;
    MemAddr         = '0;
    Hit             = 1'b0;
    InstOut         = '0;
    Stall           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (FetchReq) begin
          addr_d  = FetchAddr[31:2];
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        if (lookup_hit) begin
          Hit     = 1'b1;
          InstOut = DataRead;
          // A hit cycle can accept the next fetch, giving one hit per cycle.
          if (FetchReq) begin
            addr_d  = FetchAddr[31:2];
            state_d = LOOKUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          Stall   = 1'b1;
          state_d = REFILL;
        end
      end

      REFILL: begin
        CacheIndexRead = addr_index;
        MemReq         = 1'b1;
        MemAddr        = {addr_q, 2'b00};
        Stall          = 1'b1;
        if (MemAck) begin
          data_d  = MemData;
          state_d = UPDATE;
        end
      end

      UPDATE: begin
        // Line write and delivery happen together. A following fetch to the
        // same line reads the memories after this write edge and hits.
        CacheIndexRead  = addr_index;
        CacheIndexWrite = addr_index;
        WriteValid      = 1'b1;
        TagWrite        = addr_tag;
        DataWrite       = data_q;
        Hit             = 1'b1;
        InstOut         = data_q;
        state_d         = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef ICACHE_PERF_EN
  logic [15:0] miss_count_q, miss_count_d;

  // Counts each lookup miss once, holding at all-ones instead of wrapping.
  always_comb begin
    miss_count_d = miss_count_q;
    if ((state_q == LOOKUP) && !lookup_hit && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      miss_count_q <= '0;
    end else begin
      miss_count_q <= miss_count_d;
    end
  end

  assign MissCount = miss_count_q;
`endif

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter INDEX_W, default 7, cache index width (128 lines).
REQ-002 SHALL have parameter TAG_W, default 23, tag width (32-bit address minus 7 index bits minus 2 byte-offset bits).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- FetchReq  in  1  fetch request.
- FetchAddr  in  32  fetch byte address (word aligned).
- Valid  in  1  line valid bit from the valid memory, registered one cycle after CacheIndexRead.
- TagRead  in  TAG_W  stored tag, same timing as Valid.
- DataRead  in  32  stored instruction, same timing as Valid.
- CacheIndexRead  out  INDEX_W  index to the valid/tag/data memories.
- CacheIndexWrite  out  INDEX_W  line being refilled.
- WriteValid  out  1  write strobe: sets valid bit, writes tag and data.
- TagWrite  out  TAG_W  tag to write.
- DataWrite  out  32  instruction to write.
- MemReq  out  1  refill request to next level.
- MemAddr  out  32  refill word address.
- MemAck  in  1  refill data valid.
- MemData  in  32  refill data.
- Hit  out  1  instruction delivered this cycle.
- InstOut  out  32  delivered instruction.
- Stall  out  1  fetch stall.

Function
REQ-004 SHALL split addresses as tag = addr[31:9], index = addr[8:2]; addr[1:0] ignored.
REQ-005 SHALL implement FSM states IDLE, LOOKUP, REFILL, UPDATE.
REQ-006 In IDLE and LOOKUP, CacheIndexRead SHALL be FetchAddr index (combinational); in REFILL/UPDATE it SHALL be the latched address index.
REQ-007 IDLE: FetchReq=1 SHALL latch FetchAddr into AddrReg and go to LOOKUP; FetchReq=0 stays IDLE.
REQ-008 LOOKUP hit (Valid=1 and TagRead == AddrReg tag) SHALL assert Hit=1, InstOut=DataRead that cycle; next state LOOKUP with new AddrReg if FetchReq=1, else IDLE.
REQ-009 LOOKUP miss SHALL assert Stall=1 combinationally, ignore FetchReq, and go to REFILL.
REQ-010 REFILL SHALL hold MemReq=1, MemAddr={AddrReg[31:2],2'b00}, Stall=1 until MemAck=1; on MemAck capture MemData and go to UPDATE.
REQ-011 UPDATE SHALL pulse WriteValid=1 for exactly one cycle with CacheIndexWrite=AddrReg index, TagWrite=AddrReg tag, DataWrite=captured data, and simultaneously Hit=1, InstOut=captured data, Stall=0; next state IDLE.
REQ-012 FetchReq SHALL be accepted only in IDLE or a LOOKUP hit cycle; requester holds FetchReq/FetchAddr until Hit.
REQ-013 MemAck outside REFILL SHALL be ignored.
REQ-014 Miss latency SHALL be 1 (lookup) + N (MemAck wait, N>=1) + 1 (UPDATE) cycles from acceptance to Hit; hit latency 1 cycle after acceptance.
REQ-015 A fetch to a line written in UPDATE SHALL hit, since its lookup read occurs after the write edge.
REQ-016 When not asserted, WriteValid, MemReq, Hit, Stall SHALL be 0; CacheIndexWrite, TagWrite, DataWrite, MemAddr, InstOut are don't-care.

Reset
REQ-017 nReset=0 SHALL asynchronously force IDLE, AddrReg=0, captured data=0; all outputs 0 except CacheIndexRead.
REQ-018 Reset mid-REFILL SHALL drop MemReq immediately and abandon the refill with no WriteValid; a later MemAck is ignored.

Configuration
REQ-019 With ICACHE_PERF_EN defined, SHALL add output MissCount (16 bits, reset 0, +1 per LOOKUP miss, saturating at 0xFFFF); without it the port and counter SHALL be absent and behaviour otherwise identical.

Verification
REQ-020 Reset, Valid=0, FetchReq=1 FetchAddr=0x0000_0104 -> LOOKUP miss, MemReq=1 MemAddr=0x104; MemAck=1 MemData=0x0013_0093 after 3 cycles -> WriteValid=1 index 0x41 tag 0, Hit=1 InstOut=0x0013_0093.
REQ-021 Back-to-back hits 0x200, 0x204 with Valid=1 and matching tags -> Hit=1 on two consecutive cycles, Stall=0 throughout.
REQ-022 Tag mismatch: Valid=1, TagRead=0x1, FetchAddr=0x0000_0000 -> miss, refill at MemAddr=0x0.
REQ-023 nReset=0 during REFILL, then MemAck=1 -> MemReq=0 at once, no WriteValid, state IDLE.
REQ-024 ICACHE_PERF_EN defined, 3 misses and 2 hits -> MissCount=3; forced 0xFFFF plus one miss -> stays 0xFFFF.
